// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
// Shared definitions for the PLL lock sequencer:
//   - default values for the sequencing parameters
//   - the sequencer state enum (also exported on the debug port)
//   - a small helper used to size the shared cycle counter
package pll_ctrl_pkg;

  localparam int RST_PULSE_DEF    = 16;     // refclk cycles of PLL reset per attempt
  localparam int LOCK_TIMEOUT_DEF = 50000;  // refclk cycles allowed for lock per attempt
  localparam int LOCK_STABLE_DEF  = 1024;   // consecutive locked cycles before release
  localparam int MAX_RETRY_DEF    = 8;      // timed-out attempts before giving up

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync
// Two-flop synchroniser bringing the raw PLL lock indication into refclk.
// Ports:
//   clk - refclk, rising edge
//   rst - asynchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronised output (two refclk edges of latency)
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
// Sequences a PLL out of reset: pulses the PLL reset, waits for lock with a
// timeout and bounded retries, requires the lock to be stable for a while,
// then releases the core reset. A lock loss while running restarts the
// sequence and is counted.
// Ports:
//   refclk     - the single clock, rising edge
//   rst        - asynchronous active-high reset
//   locked_in  - raw PLL lock, asynchronous to refclk
//   restart    - one-cycle synchronous request to re-sequence from scratch
//   pll_rst    - reset to the PLL (high in PLL_RST and FAIL)
//   core_reset - reset for logic on PLL output clocks (low only in RUN)
//   ready      - lock stable and core released (high only in RUN)
//   fail       - retries exhausted; held until restart or rst
//   retry_cnt  - timed-out attempts since the last RUN or restart
//   loss_cnt   - lock losses seen in RUN, saturating at 255
//   state_dbg  - current sequencer state
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE    = RST_PULSE_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int LOCK_STABLE  = LOCK_STABLE_DEF,  // must be >= 2
  parameter int MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output pll_state_e state_dbg
);

  localparam int CNT_MAX = max3(RST_PULSE, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // The locked sample that moved WAIT_LOCK into STABLE is the first of the
  // consecutive run, so STABLE itself needs LOCK_STABLE-1 more high samples:
  // with the counter starting at 0 that is the sample seen at LOCK_STABLE-2.
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 2);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  logic locked_s;

  pll_lock_sync u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked_in),
    .q   (locked_s)
  );

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic [3:0]       retry_inc;

  assign retry_inc = retry_q + 4'd1;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PLL_RST;
      cnt_q   <= '0;
      retry_q <= 4'd0;
      loss_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // Every transition below clears the shared counter; restart overrides all
  // other events in the same cycle, including a timeout or a lock loss.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (restart) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_STABLE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q >= STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = 4'd0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          cnt_d = '0;
          if (!locked_s) begin
            state_d = ST_PLL_RST;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end

        ST_FAIL: begin
          cnt_d = '0;
        end

        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from the registered state only.
  assign pll_rst    = (state_q == ST_PLL_RST) || (state_q == ST_FAIL);
  assign core_reset = (state_q != ST_RUN);
  assign ready      = (state_q == ST_RUN);
  assign fail       = (state_q == ST_FAIL);
  assign retry_cnt  = retry_q;
  assign loss_cnt   = loss_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl
// Directed bench for pll_lock_ctrl with RST_PULSE=4, LOCK_TIMEOUT=32,
// LOCK_STABLE=8, MAX_RETRY=3.
// Cycle k means "1 time unit after the k-th rising edge following rst
// release"; inputs are driven and outputs sampled at that point.
// A locked_in change driven at cycle k is seen by the state machine at edge
// k+3 (two synchroniser edges, then the state register).
module tb_pll_lock_ctrl;
  import pll_ctrl_pkg::*;

  logic       refclk;
  logic       rst;
  logic       locked_in;
  logic       restart;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  pll_state_e state_dbg;

  int n_cmp;
  int n_bad;
  int cyc;

  pll_lock_ctrl #(
    .RST_PULSE    (4),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (8),
    .MAX_RETRY    (3)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked_in  (locked_in),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .core_reset (core_reset),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto_cycle(input int target);
    if (target > cyc) tick(target - cyc);
  endtask

  // Holds rst for a few edges, then releases it; returns at cycle 0.
  task automatic apply_reset();
    @(posedge refclk);
    #1;
    rst       = 1'b1;
    locked_in = 1'b0;
    restart   = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Waits a bounded number of cycles for ready; timeout counts as a failure.
  task automatic wait_ready(input string name, input int budget);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: ready=%b after %0d cycles, required 1", name, ready, budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge refclk);
    #1;
    rst = 1'b1; locked_in = 1'b1; restart = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    n_cmp++; if (pll_rst !== 1'b1)     begin n_bad++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    n_cmp++; if (core_reset !== 1'b1)  begin n_bad++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
    n_cmp++; if (ready !== 1'b0)       begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (fail !== 1'b0)        begin n_bad++; $display("FAIL reset_fail: got %b want 0", fail); end
    n_cmp++; if (retry_cnt !== 4'd0)   begin n_bad++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
    n_cmp++; if (loss_cnt !== 8'd0)    begin n_bad++; $display("FAIL reset_loss: got %0d want 0", loss_cnt); end
    n_cmp++; if (state_dbg !== ST_PLL_RST) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_PLL_RST); end
  endtask

  // Lock raised at cycle 10: pll_rst drops at 4, ready at 20.
  task automatic test_lock();
    apply_reset();
    goto_cycle(3);
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL lock_pll_rst_c3: got %b want 1", pll_rst); end
    goto_cycle(4);
    n_cmp++; if (pll_rst !== 1'b0) begin n_bad++; $display("FAIL lock_pll_rst_c4: got %b want 0", pll_rst); end
    goto_cycle(10);
    locked_in = 1'b1;
    goto_cycle(19);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL lock_ready_c19: got %b want 0", ready); end
    goto_cycle(20);
    n_cmp++; if (ready !== 1'b1)      begin n_bad++; $display("FAIL lock_ready_c20: got %b want 1", ready); end
    n_cmp++; if (core_reset !== 1'b0) begin n_bad++; $display("FAIL lock_core_reset_c20: got %b want 0", core_reset); end
    n_cmp++; if (retry_cnt !== 4'd0)  begin n_bad++; $display("FAIL lock_retry_c20: got %0d want 0", retry_cnt); end
  endtask

  // No lock: timeouts at 36, 72, 108; third one enters FAIL.
  task automatic test_fail();
    apply_reset();
    goto_cycle(35);
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL fail_retry_c35: got %0d want 0", retry_cnt); end
    goto_cycle(36);
    n_cmp++; if (retry_cnt !== 4'd1) begin n_bad++; $display("FAIL fail_retry_c36: got %0d want 1", retry_cnt); end
    n_cmp++; if (pll_rst !== 1'b1)   begin n_bad++; $display("FAIL fail_pll_rst_c36: got %b want 1", pll_rst); end
    goto_cycle(72);
    n_cmp++; if (retry_cnt !== 4'd2) begin n_bad++; $display("FAIL fail_retry_c72: got %0d want 2", retry_cnt); end
    goto_cycle(107);
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL fail_flag_c107: got %b want 0", fail); end
    goto_cycle(108);
    n_cmp++; if (fail !== 1'b1)       begin n_bad++; $display("FAIL fail_flag_c108: got %b want 1", fail); end
    n_cmp++; if (retry_cnt !== 4'd3)  begin n_bad++; $display("FAIL fail_retry_c108: got %0d want 3", retry_cnt); end
    n_cmp++; if (pll_rst !== 1'b1)    begin n_bad++; $display("FAIL fail_pll_rst_c108: got %b want 1", pll_rst); end
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL fail_core_reset_c108: got %b want 1", core_reset); end
    goto_cycle(140);
    n_cmp++; if (fail !== 1'b1 || pll_rst !== 1'b1) begin n_bad++; $display("FAIL fail_sticky: fail=%b pll_rst=%b want 1/1", fail, pll_rst); end
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    n_cmp++; if (fail !== 1'b0)      begin n_bad++; $display("FAIL fail_restart_flag: got %b want 0", fail); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL fail_restart_retry: got %0d want 0", retry_cnt); end
    n_cmp++; if (state_dbg !== ST_PLL_RST) begin n_bad++; $display("FAIL fail_restart_state: got %0d want %0d", state_dbg, ST_PLL_RST); end
    goto_cycle(145);
    n_cmp++; if (pll_rst !== 1'b0) begin n_bad++; $display("FAIL fail_restart_wait: pll_rst=%b want 0", pll_rst); end
  endtask

  // One timeout (retry=1), lock at 40 -> STABLE at 43, 3-cycle glitch
  // driven at 44..46 -> WAIT_LOCK at 47, STABLE again at 50, RUN at 57.
  task automatic test_glitch();
    apply_reset();
    goto_cycle(36);
    n_cmp++; if (retry_cnt !== 4'd1) begin n_bad++; $display("FAIL glitch_retry_c36: got %0d want 1", retry_cnt); end
    goto_cycle(40);
    locked_in = 1'b1;
    goto_cycle(43);
    n_cmp++; if (state_dbg !== ST_STABLE) begin n_bad++; $display("FAIL glitch_state_c43: got %0d want %0d", state_dbg, ST_STABLE); end
    goto_cycle(44);
    locked_in = 1'b0;
    goto_cycle(47);
    locked_in = 1'b1;
    n_cmp++; if (state_dbg !== ST_WAIT_LOCK) begin n_bad++; $display("FAIL glitch_state_c47: got %0d want %0d", state_dbg, ST_WAIT_LOCK); end
    n_cmp++; if (retry_cnt !== 4'd1) begin n_bad++; $display("FAIL glitch_retry_c47: got %0d want 1", retry_cnt); end
    goto_cycle(49);
    n_cmp++; if (state_dbg !== ST_WAIT_LOCK) begin n_bad++; $display("FAIL glitch_state_c49: got %0d want %0d", state_dbg, ST_WAIT_LOCK); end
    goto_cycle(50);
    n_cmp++; if (state_dbg !== ST_STABLE) begin n_bad++; $display("FAIL glitch_state_c50: got %0d want %0d", state_dbg, ST_STABLE); end
    goto_cycle(56);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL glitch_ready_c56: got %b want 0", ready); end
    goto_cycle(57);
    n_cmp++; if (ready !== 1'b1)     begin n_bad++; $display("FAIL glitch_ready_c57: got %b want 1", ready); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL glitch_retry_c57: got %0d want 0", retry_cnt); end
  endtask

  // Restart on the same edge as a WAIT_LOCK timeout (edge 36).
  task automatic test_restart_timeout();
    apply_reset();
    goto_cycle(35);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL rto_retry: got %0d want 0", retry_cnt); end
    n_cmp++; if (state_dbg !== ST_PLL_RST) begin n_bad++; $display("FAIL rto_state: got %0d want %0d", state_dbg, ST_PLL_RST); end
    goto_cycle(39);
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL rto_pll_rst_c39: got %b want 1", pll_rst); end
    goto_cycle(40);
    n_cmp++; if (pll_rst !== 1'b0) begin n_bad++; $display("FAIL rto_pll_rst_c40: got %b want 0", pll_rst); end
  endtask

  // Lock losses from RUN, restart racing a loss, saturation, async rst.
  task automatic test_loss();
    int t;
    test_lock();
    t = cyc;
    locked_in = 1'b0;
    tick(1);
    locked_in = 1'b1;
    tick(1);
    n_cmp++; if (ready !== 1'b1 || pll_rst !== 1'b0) begin n_bad++; $display("FAIL loss_early: ready=%b pll_rst=%b want 1/0", ready, pll_rst); end
    tick(1);
    n_cmp++; if (pll_rst !== 1'b1 || core_reset !== 1'b1 || ready !== 1'b0) begin n_bad++; $display("FAIL loss_outputs: pll_rst=%b core_reset=%b ready=%b want 1/1/0", pll_rst, core_reset, ready); end
    n_cmp++; if (loss_cnt !== 8'd1) begin n_bad++; $display("FAIL loss_first: got %0d want 1 (cycle %0d)", loss_cnt, cyc - t); end
    wait_ready("loss_relock_1", 40);

    // Loss and restart reach the state machine on the same edge.
    locked_in = 1'b0;
    tick(1);
    locked_in = 1'b1;
    tick(1);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    n_cmp++; if (loss_cnt !== 8'd1)  begin n_bad++; $display("FAIL loss_restart_cnt: got %0d want 1", loss_cnt); end
    n_cmp++; if (pll_rst !== 1'b1)   begin n_bad++; $display("FAIL loss_restart_pll_rst: got %b want 1", pll_rst); end
    wait_ready("loss_relock_r", 40);

    for (int i = 2; i <= 256; i++) begin
      locked_in = 1'b0;
      tick(1);
      locked_in = 1'b1;
      tick(2);
      if (i == 2) begin
        n_cmp++; if (loss_cnt !== 8'd2) begin n_bad++; $display("FAIL loss_second: got %0d want 2", loss_cnt); end
      end
      if (i == 255) begin
        n_cmp++; if (loss_cnt !== 8'd255) begin n_bad++; $display("FAIL loss_255: got %0d want 255", loss_cnt); end
      end
      if (i == 256) begin
        n_cmp++; if (loss_cnt !== 8'd255) begin n_bad++; $display("FAIL loss_saturate: got %0d want 255", loss_cnt); end
      end
      wait_ready("loss_relock_loop", 40);
    end

    // Asynchronous rst mid-cycle while in RUN.
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (pll_rst !== 1'b1 || core_reset !== 1'b1 || ready !== 1'b0 || fail !== 1'b0) begin n_bad++; $display("FAIL async_rst_outputs: pll_rst=%b core_reset=%b ready=%b fail=%b want 1/1/0/0", pll_rst, core_reset, ready, fail); end
    n_cmp++; if (loss_cnt !== 8'd0 || retry_cnt !== 4'd0) begin n_bad++; $display("FAIL async_rst_counts: loss=%0d retry=%0d want 0/0", loss_cnt, retry_cnt); end
    n_cmp++; if (state_dbg !== ST_PLL_RST) begin n_bad++; $display("FAIL async_rst_state: got %0d want %0d", state_dbg, ST_PLL_RST); end
    #2;
    rst = 1'b0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    rst = 1'b1;
    locked_in = 1'b0;
    restart = 1'b0;
    test_reset();
    test_lock();
    test_fail();
    test_glitch();
    test_restart_timeout();
    test_loss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
